// File: rtl/apb_pkg.sv
// apb_pkg: shared definitions for the APB requester and the USRT completer side.
// Holds the bridge FSM encoding, default bus widths and the command/response bundles.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic                  err;
        logic [APB_DATA_W-1:0] rdata;
    } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts ACCESS wait cycles and flags the cycle in which the
// wait budget runs out. Only built when APB_TIMEOUT_EN is defined.
`ifdef APB_TIMEOUT_EN
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expire
);

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] r_count;

    // Wait-cycle counter: held at zero outside ACCESS, steps on every stalled ACCESS cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expire = i_inc && (r_count == LP_LAST);

endmodule
`endif

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: APB requester that takes one read/write command at a time,
// runs the SETUP/ACCESS sequence and returns a single-cycle response pulse.
// All outputs come straight from registers.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase that has been
// stalled for TIMEOUT_CYC cycles; the abort is reported through rsp_err.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
`ifdef APB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 16
`endif
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              pSelect,
    output logic              pEnable,
    output logic              pWrite,
    output logic [ADDR_W-1:0] pAddress,
    output logic [DATA_W-1:0] pWData,
    input  logic [DATA_W-1:0] pRData,
    input  logic              pReady
);

    apb_state_e        r_state;
    apb_state_e        w_stateNext;
    logic              r_cmdReady;
    logic              w_cmdReadyNext;
    logic              r_pSelect;
    logic              w_pSelectNext;
    logic              r_pEnable;
    logic              w_pEnableNext;
    logic              r_pWrite;
    logic              w_pWriteNext;
    logic [ADDR_W-1:0] r_pAddress;
    logic [ADDR_W-1:0] w_pAddressNext;
    logic [DATA_W-1:0] r_pWData;
    logic [DATA_W-1:0] w_pWDataNext;
    logic              r_rspValid;
    logic              w_rspValidNext;
    logic [DATA_W-1:0] r_rspRdata;
    logic [DATA_W-1:0] w_rspRdataNext;
    logic              r_rspErr;
    logic              w_rspErrNext;
    logic              w_expire;

`ifdef APB_TIMEOUT_EN
    logic w_toClear;
    logic w_toInc;

    assign w_toClear = (r_state != ACCESS);
    assign w_toInc   = (r_state == ACCESS) && !pReady;

    apb_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .i_clk    (pClk),
        .i_rst_n  (pReset),
        .i_clear  (w_toClear),
        .i_inc    (w_toInc),
        .o_expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // Next-state and next-output logic; the address/data phase is captured on acceptance
    // and simply held afterwards, so only the handshake bits change per phase.
    always_comb begin
        w_stateNext    = r_state;
        w_pSelectNext  = r_pSelect;
        w_pEnableNext  = r_pEnable;
        w_pWriteNext   = r_pWrite;
        w_pAddressNext = r_pAddress;
        w_pWDataNext   = r_pWData;
        w_rspValidNext = 1'b0;
        w_rspErrNext   = 1'b0;
        w_rspRdataNext = r_rspRdata;

        case (r_state)
            IDLE: begin
                w_pSelectNext = 1'b0;
                w_pEnableNext = 1'b0;
                if (cmd_valid && r_cmdReady) begin
                    w_stateNext    = SETUP;
                    w_pSelectNext  = 1'b1;
                    w_pWriteNext   = cmd_write;
                    w_pAddressNext = cmd_addr;
                    w_pWDataNext   = cmd_write ? cmd_wdata : '0;
                end
            end
            SETUP: begin
                w_stateNext   = ACCESS;
                w_pSelectNext = 1'b1;
                w_pEnableNext = 1'b1;
            end
            ACCESS: begin
                if (pReady) begin
                    w_stateNext    = IDLE;
                    w_pSelectNext  = 1'b0;
                    w_pEnableNext  = 1'b0;
                    w_rspValidNext = 1'b1;
                    w_rspRdataNext = r_pWrite ? '0 : pRData;
                end else if (w_expire) begin
                    w_stateNext    = IDLE;
                    w_pSelectNext  = 1'b0;
                    w_pEnableNext  = 1'b0;
                    w_rspValidNext = 1'b1;
                    w_rspErrNext   = 1'b1;
                    w_rspRdataNext = '0;
                end
            end
            default: begin
                w_stateNext   = IDLE;
                w_pSelectNext = 1'b0;
                w_pEnableNext = 1'b0;
            end
        endcase

        w_cmdReadyNext = (w_stateNext == IDLE);
    end

    // State and output registers; reset leaves the bridge idle and ready for a command.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            r_state    <= IDLE;
            r_cmdReady <= 1'b1;
            r_pSelect  <= 1'b0;
            r_pEnable  <= 1'b0;
            r_pWrite   <= 1'b0;
            r_pAddress <= '0;
            r_pWData   <= '0;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
            r_rspErr   <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cmdReady <= w_cmdReadyNext;
            r_pSelect  <= w_pSelectNext;
            r_pEnable  <= w_pEnableNext;
            r_pWrite   <= w_pWriteNext;
            r_pAddress <= w_pAddressNext;
            r_pWData   <= w_pWDataNext;
            r_rspValid <= w_rspValidNext;
            r_rspRdata <= w_rspRdataNext;
            r_rspErr   <= w_rspErrNext;
        end
    end

    assign cmd_ready = r_cmdReady;
    assign pSelect   = r_pSelect;
    assign pEnable   = r_pEnable;
    assign pWrite    = r_pWrite;
    assign pAddress  = r_pAddress;
    assign pWData    = r_pWData;
    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspRdata;
    assign rsp_err   = r_rspErr;

endmodule
